test_harness: RTL and testbench

TEST_HARNESS -- requirements
Module: test_harness

---
 rtl/test_harness_pkg.sv | 29 ++
 rtl/harness_lfsr.sv | 31 +++
 rtl/test_harness.sv | 135 +++++++++++++
 tb/tb_test_harness.sv | 111 +++++++++++
 4 files changed

// File: rtl/test_harness_pkg.sv
// rtl/test_harness_pkg.sv - shared types, LFSR constants and helpers for the memory self-test
// Purpose: FSM state encoding, Galois LFSR polynomial, default seed and the
//          next-state / seed-sanitising helpers used by the LFSR generators.
// Ports:   none (package).
package test_harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_PASS,
    ST_FAIL
  } state_t;

  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

  // One Galois step: shift right, fold the polynomial in when bit 0 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

  // An all-zero state would lock the LFSR, so zero is promoted to one.
  function automatic logic [31:0] safe_seed(input logic [31:0] s);
    return (s == 32'h0) ? 32'h0000_0001 : s;
  endfunction

endpackage

// File: rtl/harness_lfsr.sv
// rtl/harness_lfsr.sv - 32-bit Galois LFSR with load and step controls
// Purpose: pattern source for the self-test; one instance generates write
//          data, another regenerates the expected read data.
// Ports:   clk   - clock, rising edge
//          reset - synchronous active-high reset, loads the seed
//          load  - reload the seed this edge (has priority over step)
//          step  - advance one LFSR step this edge
//          state - current 32-bit LFSR value
module harness_lfsr
  import test_harness_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  output logic [31:0] state
);

  localparam logic [31:0] SEED_EFF = safe_seed(SEED);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      state <= SEED_EFF;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/test_harness.sv
// rtl/test_harness.sv - built-in RAM self-test: LFSR pattern write, read-back and compare
// Purpose: writes an LFSR sequence into an inline DEPTH x WIDTH RAM, reads it
//          back with one-cycle latency and compares against a second LFSR.
// Ports:   clk        - clock, rising edge
//          reset      - synchronous active-high reset, restarts the test
//          io_success - 1 only once the test has passed; sticky until reset
module test_harness
  import test_harness_pkg::*;
#(
  parameter int          DEPTH      = 16,
  parameter int          WIDTH      = 32,
  parameter logic [31:0] SEED       = DEFAULT_SEED,
  parameter int          FAULT_ADDR = -1
) (
  input  logic clk,
  input  logic reset,
  output logic io_success
);

  // One spare bit so the counter can never wrap inside a pass.
  localparam int AW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t           state;
  logic [AW-1:0]    addr;
  logic             rd_valid;
  logic             mismatch;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] ram [DEPTH];

  logic [31:0]      wr_state;
  logic [31:0]      exp_state;
  logic             last;
  logic             fault_hit;
  logic [WIDTH-1:0] wr_data;
  logic             cmp_bad;
  logic [IW-1:0]    ram_idx;

  assign last      = (addr == LAST_ADDR);
  assign ram_idx   = IW'(addr);
  assign fault_hit = (FAULT_ADDR >= 0) && (int'(addr) == FAULT_ADDR);
  assign wr_data   = WIDTH'(wr_state) ^ WIDTH'({31'h0, fault_hit});
  // rd_valid marks the cycle after a read request, when rd_data holds that word.
  assign cmp_bad   = rd_valid && (rd_data != WIDTH'(exp_state));

  harness_lfsr #(.SEED(SEED)) u_wr_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (state == ST_IDLE),
    .step  (state == ST_WRITE),
    .state (wr_state)
  );

  // Re-seeded on the edge that enters READ, stepped after each compare.
  harness_lfsr #(.SEED(SEED)) u_exp_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  ((state == ST_WRITE) && last),
    .step  (rd_valid),
    .state (exp_state)
  );

  // Inline RAM: synchronous write, registered read, contents never reset.
  always_ff @(posedge clk) begin
    if (state == ST_WRITE) begin
      ram[ram_idx] <= wr_data;
    end
    if (state == ST_READ) begin
      rd_data <= ram[ram_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      addr       <= '0;
      rd_valid   <= 1'b0;
      mismatch   <= 1'b0;
      io_success <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_WRITE;
          addr  <= '0;
        end
        ST_WRITE: begin
          if (last) begin
            state <= ST_READ;
            addr  <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        ST_READ: begin
          if (cmp_bad) begin
            state    <= ST_FAIL;
            mismatch <= 1'b1;
            rd_valid <= 1'b0;
          end else begin
            rd_valid <= 1'b1;
            if (last) begin
              state <= ST_DRAIN;
              addr  <= '0;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          rd_valid <= 1'b0;
          if (cmp_bad || mismatch) begin
            state    <= ST_FAIL;
            mismatch <= 1'b1;
          end else begin
            state      <= ST_PASS;
            io_success <= 1'b1;
          end
        end
        ST_PASS: begin
          io_success <= 1'b1;
        end
        ST_FAIL: begin
          rd_valid   <= 1'b0;
          io_success <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          io_success <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_harness.sv
// tb/tb_test_harness.sv - scoreboard bench for the RAM self-test harness
// Purpose: runs four configurations (default, fault at 5, DEPTH=1, SEED=0)
//          on one clock and compares io_success against a timing model.
// Ports:   none (top-level bench).
module tb_test_harness;
  import test_harness_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ok_def, ok_flt, ok_d1, ok_s0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  test_harness u_def (.clk(clk), .reset(reset), .io_success(ok_def));
  test_harness #(.FAULT_ADDR(5)) u_flt (.clk(clk), .reset(reset), .io_success(ok_flt));
  test_harness #(.DEPTH(1)) u_d1 (.clk(clk), .reset(reset), .io_success(ok_d1));
  test_harness #(.SEED(32'h0)) u_s0 (.clk(clk), .reset(reset), .io_success(ok_s0));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] v);
    logic [31:0] r;
    r = {1'b0, v[31:1]};
    if (v[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  // Expected io_success per edge: 1 once 2*DEPTH+2 edges with reset low have
  // been seen since the last reset, and only for fault-free instances.
  int rel_cnt = 0;
  logic [3:0] sb_q[$];

  always @(posedge clk) begin
    logic [3:0] e;
    if (reset) rel_cnt = 0;
    else rel_cnt = rel_cnt + 1;
    e[0] = !reset && (rel_cnt >= 34);
    e[1] = 1'b0;
    e[2] = !reset && (rel_cnt >= 4);
    e[3] = !reset && (rel_cnt >= 34);
    sb_q.push_back(e);
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("io_success default", {31'h0, ok_def}, {31'h0, e[0]});
      check_eq("io_success fault5", {31'h0, ok_flt}, {31'h0, e[1]});
      check_eq("io_success depth1", {31'h0, ok_d1}, {31'h0, e[2]});
      check_eq("io_success seed0", {31'h0, ok_s0}, {31'h0, e[3]});
    end
  end

  initial begin
    logic [31:0] w;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;

    // Phase 1: plain run from reset.
    repeat (20) @(negedge clk);
    check_eq("ram0 default", u_def.ram[0], 32'hACE1_0001);
    check_eq("ram1 default", u_def.ram[1], ref_step(32'hACE1_0001));
    check_eq("ram1 literal", u_def.ram[1], 32'hD650_8003);
    w = 32'hACE1_0001;
    for (int i = 0; i < 5; i++) w = ref_step(w);
    check_eq("ram5 fault inverted", u_flt.ram[5], w ^ 32'h1);
    check_eq("ram4 fault clean", u_flt.ram[4], u_def.ram[4]);
    check_eq("ram0 seed0", u_s0.ram[0], 32'h0000_0001);
    check_eq("ram1 seed0", u_s0.ram[1], ref_step(32'h1));
    repeat (3) @(negedge clk);
    check_eq("fault not yet FAIL e23", {31'h0, u_flt.state == ST_FAIL}, 32'h0);
    repeat (1) @(negedge clk);
    check_eq("fault FAIL e24", {31'h0, u_flt.state == ST_FAIL}, 32'h1);
    repeat (126) @(negedge clk);

    // Phase 2: reset pulse, then a second reset mid-WRITE at edge 10.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (150) @(negedge clk);

    // Phase 3: reset while in PASS, then a long run covering the fault hold.
    check_eq("pass before reset", {31'h0, ok_def}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (1100) @(negedge clk);
    check_eq("fault terminal", {31'h0, u_flt.state == ST_FAIL}, 32'h1);
    check_eq("pass terminal", {31'h0, u_def.state == ST_PASS}, 32'h1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
